fwd_scoreboard: RTL
===================

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameter DW, 32, datapath width.
REQ-002 Parameter AW, 5, register address width.
REQ-003 Parameter DEPTH, 3, in-flight producer stages tracked (slot 0 = EX, DEPTH-1 = WB); legal 2..8.
REQ-004 Parameter NRP, 2, consumer read ports; legal 1..4.
REQ-005 Parameter LOAD_STAGE, 1, first slot index at which load data is valid; legal 1..DEPTH-1.
REQ-006 Parameter CW, 16, stall counter width.
REQ-007 clk  in  1  single clock; all state on rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 stall  in  1  external pipeline hold; slots do not advance.
REQ-010 flush  in  1  discard all in-flight entries.
REQ-011 iss_valid  in  1  ID holds a valid instruction this cycle.
REQ-012 iss_wreg  in  1  issuing instruction writes a register.
REQ-013 iss_waddr  in  AW  issuing destination register.
REQ-014 iss_load  in  1  issuing instruction is a load.
REQ-015 rd_en  in  NRP  per-port operand read enable.
REQ-016 rd_addr  in  NRP*AW  per-port source register, port p at bits [p*AW +: AW].
REQ-017 stg_wdata  in  DEPTH*DW  result data of the instruction in slot k at [k*DW +: DW].
REQ-018 fwd_hit  out  NRP  port p takes forwarded data.
REQ-019 fwd_data  out  NRP*DW  forwarded value per port.
REQ-020 stall_req  out  1  load-use hazard; ID must hold.
REQ-021 busy  out  1  any slot valid.
REQ-022 stall_cnt  out  CW  cycles lost to load-use hazards.

Function
REQ-023 Each slot SHALL hold {valid, wreg, waddr, load}; state is registered, all lookup outputs combinational from slots and inputs.
REQ-024 Advance (stall=0, flush=0): slot k+1 <= slot k; slot DEPTH-1 content retires.
REQ-025 On advance, slot 0 SHALL load the issuing record iff iss_valid=1 and stall_req=0, else a bubble (valid=0).
REQ-026 stall=1 and flush=0: all slots hold; no issue accepted.
REQ-027 flush=1: all slots invalid next cycle regardless of stall, iss_valid, stall_req; flush wins all simultaneous events.
REQ-028 Slot k matches port p iff valid, wreg, waddr==rd_addr[p], rd_en[p]=1, rd_addr[p]!=0.
REQ-029 Priority: lowest-index (youngest) matching slot only; older matches ignored.
REQ-030 Slot k data ready iff load=0 or k>=LOAD_STAGE.
REQ-031 Youngest match ready: fwd_hit[p]=1, fwd_data[p]=stg_wdata of that slot.
REQ-032 No match, or match not ready: fwd_hit[p]=0, fwd_data[p]=0.
REQ-033 stall_req=1 iff iss_valid=1 and any port's youngest match is not ready; zero latency (same cycle).
REQ-034 Register 0 SHALL never match, hit, or stall.
REQ-035 busy = OR of slot valid bits.
REQ-036 stall_cnt SHALL increment by 1 each cycle with stall_req=1 and stall=0 and flush=0; saturates at 2^CW-1, no wrap.
REQ-037 A load-use bubble SHALL resolve without external action: load advances to LOAD_STAGE, stall_req falls, forwarding hits.

Reset
REQ-038 rst=1 SHALL immediately, without clock, clear all slot valid bits and stall_cnt to 0.
REQ-039 During and after reset: fwd_hit=0, fwd_data=0, stall_req=0, busy=0, stall_cnt=0.
REQ-040 Reset mid-operation SHALL discard in-flight entries; first post-reset edge with iss_valid=1 issues normally.

Verification
REQ-041 Issue ADD r3 (non-load), next cycle read r3 on port 0, stg_wdata slot0=0x0000_1234 -> fwd_hit[0]=1, fwd_data=0x0000_1234, stall_req=0.
REQ-042 Issue LW r5, next cycle read r5 -> stall_req=1 for 1 cycle, stall_cnt 0->1; next cycle slot1 hit, fwd_data=slot1 data.
REQ-043 r7 written in slot 2 (0xAAAA_AAAA) and slot 0 (0x5555_5555), both ports read r7 -> both ports 0x5555_5555.
REQ-044 Issue writes to r0, then read r0 -> fwd_hit=0, stall_req=0; stall=1 for 3 cycles with entries present -> slots unchanged, busy=1.
REQ-045 flush=1 together with stall=1 and pending load-use -> next cycle busy=0, stall_req=0, stall_cnt unchanged.
REQ-046 Force stall_cnt to 2^CW-1 by sustained load-use with CW=2 -> holds at 3; assert rst mid-cycle -> all outputs 0 before next edge.

Source files
------------

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks in-flight register writers per pipeline slot,
// selects the youngest ready producer per read port and flags load-use hazards.
module fwd_scoreboard #(
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int DEPTH      = 3,
  parameter int NRP        = 2,
  parameter int LOAD_STAGE = 1,
  parameter int CW         = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic                iss_valid,
  input  logic                iss_wreg,
  input  logic [AW-1:0]       iss_waddr,
  input  logic                iss_load,
  input  logic [NRP-1:0]      rd_en,
  input  logic [NRP*AW-1:0]   rd_addr,
  input  logic [DEPTH*DW-1:0] stg_wdata,
  output logic [NRP-1:0]      fwd_hit,
  output logic [NRP*DW-1:0]   fwd_data,
  output logic                stall_req,
  output logic                busy,
  output logic [CW-1:0]       stall_cnt
);

  typedef struct packed {
    logic          valid;
    logic          wreg;
    logic [AW-1:0] waddr;
    logic          load;
  } slot_t;

  slot_t         r_slot [DEPTH];
  logic [CW-1:0] r_stall_cnt;

  logic [NRP-1:0]    w_found;
  logic [NRP-1:0]    w_pend;
  logic [NRP-1:0]    w_hit;
  logic [NRP*DW-1:0] w_data;
  logic              w_stall_req;
  logic              w_busy;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_found = '0;
    w_pend  = '0;
    w_hit   = '0;
    w_data  = '0;
    w_busy  = 1'b0;
    for (int k = 0; k < DEPTH; k++) w_busy = w_busy | r_slot[k].valid;
    for (int p = 0; p < NRP; p++) begin
      // Scan from youngest slot; first match wins, older producers are shadowed.
      for (int k = 0; k < DEPTH; k++) begin
        if (!w_found[p] && r_slot[k].valid && r_slot[k].wreg && rd_en[p] &&
            (|rd_addr[p*AW +: AW]) && (r_slot[k].waddr == rd_addr[p*AW +: AW])) begin
          w_found[p] = 1'b1;
          if (!r_slot[k].load || (k >= LOAD_STAGE)) begin
            w_hit[p]            = 1'b1;
            w_data[p*DW +: DW]  = stg_wdata[k*DW +: DW];
          end else begin
            w_pend[p] = 1'b1;
          end
        end
      end
    end
    w_stall_req = iss_valid & (|w_pend);
  end

  // NOTE: sequential state uses non-blocking assignments so the slot shift reads
  // every slot's pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) r_slot[k] <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (flush) begin
        for (int k = 0; k < DEPTH; k++) r_slot[k].valid <= 1'b0;
      end else if (!stall) begin
        for (int k = 1; k < DEPTH; k++) r_slot[k] <= r_slot[k-1];
        if (iss_valid && !w_stall_req) begin
          r_slot[0].valid <= 1'b1;
          r_slot[0].wreg  <= iss_wreg;
          r_slot[0].waddr <= iss_waddr;
          r_slot[0].load  <= iss_load;
        end else begin
          r_slot[0] <= '0;
        end
      end
      if (w_stall_req && !stall && !flush && (r_stall_cnt != {CW{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CW'(1);
    end
  end

  assign fwd_hit   = w_hit;
  assign fwd_data  = w_data;
  assign stall_req = w_stall_req;
  assign busy      = w_busy;
  assign stall_cnt = r_stall_cnt;

endmodule
